trap_ctrl: RTL and testbench

Privileged trap and return sequencer for the RV32 core. It consumes the exception and return requests that instruction decode raises (exception valid plus code, return valid plus return-from mode). It saves and restores the privileged state (current mode, epc, cause, status bits), and issues a one-shot redirect plus a flush to the fetch stage. It also owns the trap-related CSRs and serves their read/write port for the CSR datapath.

---
 rtl/trap_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Privileged trap/xRET sequencer: owns mstatus/medeleg/mtvec/mepc/mcause (plus the
// supervisor CSR set and delegation when TRAP_SMODE_EN is defined) and redirects fetch.
module trap_ctrl #(
    parameter logic [31:0] TVEC_RESET = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        excep_valid,
    input  logic [3:0]  excep_code,
    input  logic [31:0] excep_pc,
    input  logic        ret_valid,
    input  logic [1:0]  ret_from,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic [1:0]  mode,
    output logic        busy,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [1:0]  dbg_state
);
    localparam logic [1:0] USER    = 2'd0;
    localparam logic [1:0] SUPERV  = 2'd1;
    localparam logic [1:0] MACHINE = 2'd3;
`ifdef TRAP_SMODE_EN
    localparam bit SMODE = 1'b1;
`else
    localparam bit SMODE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, SAVE = 2'd1, REDIRECT = 2'd2} state_e;

    // Handshake: no ready signal. A request seen in IDLE is consumed that cycle;
    // while busy is high decode must hold its request, and anything presented is ignored.
    state_e      state_q, state_d;
    logic [3:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic        ret_q, ret_d;
    logic [1:0]  rfrom_q, rfrom_d;
    logic [29:0] tgt_q, tgt_d;
    logic [1:0]  mode_q, mode_d;
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [1:0]  mpp_q, mpp_d;
    logic [29:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
`ifdef TRAP_SMODE_EN
    logic        sie_q, sie_d, spie_q, spie_d, spp_q, spp_d;
    logic [29:0] stvec_q, stvec_d, sepc_q, sepc_d;
    logic [31:0] scause_q, scause_d;
    logic [15:0] medeleg_q, medeleg_d;
`endif

    logic accept, ret_ok, to_s;

    // Only modes that exist in this build may be stored in MPP.
    function automatic logic [1:0] legal_mpp(input logic [1:0] m);
        if (m == MACHINE)              return MACHINE;
        else if (SMODE && m == SUPERV) return SUPERV;
        else                           return USER;
    endfunction

    assign accept = (state_q == IDLE) && (excep_valid || ret_valid);
    assign ret_ok = (ret_from <= mode_q) &&
                    ((ret_from == MACHINE) || (SMODE && ret_from == SUPERV));
`ifdef TRAP_SMODE_EN
    assign to_s = (mode_q != MACHINE) && medeleg_q[code_q];
`else
    assign to_s = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        pc_d     = pc_q;
        ret_d    = ret_q;
        rfrom_d  = rfrom_q;
        tgt_d    = tgt_q;
        mode_d   = mode_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mpp_d    = mpp_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
`ifdef TRAP_SMODE_EN
        sie_d     = sie_q;
        spie_d    = spie_q;
        spp_d     = spp_q;
        stvec_d   = stvec_q;
        sepc_d    = sepc_q;
        scause_d  = scause_q;
        medeleg_d = medeleg_q;
`endif
        case (state_q)
            IDLE: begin
                if (excep_valid) begin
                    state_d = SAVE;
                    ret_d   = 1'b0;
                    code_d  = excep_code;
                    pc_d    = excep_pc;
                end else if (ret_valid) begin
                    // Illegal or unsupported returns become an illegal-instruction trap here.
                    state_d = SAVE;
                    pc_d    = excep_pc;
                    rfrom_d = ret_from;
                    ret_d   = ret_ok;
                    code_d  = 4'd2;
                end else if (csr_we) begin
                    case (csr_addr)
                        12'h300: begin
                            mie_d  = csr_wdata[3];
                            mpie_d = csr_wdata[7];
                            mpp_d  = legal_mpp(csr_wdata[12:11]);
                        end
                        12'h305: mtvec_d  = csr_wdata[31:2];
                        12'h341: mepc_d   = csr_wdata[31:2];
                        12'h342: mcause_d = csr_wdata;
`ifdef TRAP_SMODE_EN
                        12'h302: medeleg_d = csr_wdata[15:0];
                        12'h100: begin
                            sie_d  = csr_wdata[1];
                            spie_d = csr_wdata[5];
                            spp_d  = csr_wdata[8];
                        end
                        12'h105: stvec_d  = csr_wdata[31:2];
                        12'h141: sepc_d   = csr_wdata[31:2];
                        12'h142: scause_d = csr_wdata;
`endif
                        default: ;
                    endcase
                end
            end
            SAVE: begin
                state_d = REDIRECT;
                if (ret_q) begin
                    if (rfrom_q == MACHINE) begin
                        mode_d = mpp_q;
                        mie_d  = mpie_q;
                        mpie_d = 1'b1;
                        mpp_d  = USER;
                        tgt_d  = mepc_q;
                    end
`ifdef TRAP_SMODE_EN
                    else begin
                        mode_d = {1'b0, spp_q};
                        sie_d  = spie_q;
                        spie_d = 1'b1;
                        spp_d  = 1'b0;
                        tgt_d  = sepc_q;
                    end
`endif
                end
`ifdef TRAP_SMODE_EN
                else if (to_s) begin
                    sepc_d   = pc_q[31:2];
                    scause_d = {28'b0, code_q};
                    spp_d    = mode_q[0];
                    spie_d   = sie_q;
                    sie_d    = 1'b0;
                    mode_d   = SUPERV;
                    tgt_d    = stvec_q;
                end
`endif
                else begin
                    mepc_d   = pc_q[31:2];
                    mcause_d = {28'b0, code_q};
                    mpp_d    = legal_mpp(mode_q);
                    mpie_d   = mie_q;
                    mie_d    = 1'b0;
                    mode_d   = MACHINE;
                    tgt_d    = mtvec_q;
                end
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            12'h300: begin
                csr_rdata[3]     = mie_q;
                csr_rdata[7]     = mpie_q;
                csr_rdata[12:11] = mpp_q;
            end
            12'h305: csr_rdata = {mtvec_q, 2'b00};
            12'h341: csr_rdata = {mepc_q, 2'b00};
            12'h342: csr_rdata = mcause_q;
`ifdef TRAP_SMODE_EN
            12'h302: csr_rdata = {16'h0, medeleg_q};
            12'h100: begin
                csr_rdata[1] = sie_q;
                csr_rdata[5] = spie_q;
                csr_rdata[8] = spp_q;
            end
            12'h105: csr_rdata = {stvec_q, 2'b00};
            12'h141: csr_rdata = {sepc_q, 2'b00};
            12'h142: csr_rdata = scause_q;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            code_q   <= '0;
            pc_q     <= '0;
            ret_q    <= 1'b0;
            rfrom_q  <= '0;
            tgt_q    <= '0;
            mode_q   <= MACHINE;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mpp_q    <= USER;
            mtvec_q  <= TVEC_RESET[31:2];
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            pc_q     <= pc_d;
            ret_q    <= ret_d;
            rfrom_q  <= rfrom_d;
            tgt_q    <= tgt_d;
            mode_q   <= mode_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mpp_q    <= mpp_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

`ifdef TRAP_SMODE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sie_q     <= 1'b0;
            spie_q    <= 1'b0;
            spp_q     <= 1'b0;
            stvec_q   <= TVEC_RESET[31:2];
            sepc_q    <= '0;
            scause_q  <= '0;
            medeleg_q <= '0;
        end else begin
            sie_q     <= sie_d;
            spie_q    <= spie_d;
            spp_q     <= spp_d;
            stvec_q   <= stvec_d;
            sepc_q    <= sepc_d;
            scause_q  <= scause_d;
            medeleg_q <= medeleg_d;
        end
    end
`endif

    // flush covers the accepting cycle combinationally, then the whole busy window.
    assign busy           = (state_q != IDLE);
    assign flush          = busy || accept;
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = {tgt_q, 2'b00};
    assign mode           = mode_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios, then random traps/returns/CSR
// writes checked against a privilege-state reference model.
module tb_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        excep_valid = 1'b0;
  logic [3:0]  excep_code = '0;
  logic [31:0] excep_pc = '0;
  logic        ret_valid = 1'b0;
  logic [1:0]  ret_from = '0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic [1:0]  mode;
  logic        busy, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  dbg_state;

`ifdef TRAP_SMODE_EN
  localparam bit SMODE = 1'b1;
`else
  localparam bit SMODE = 1'b0;
`endif

  trap_ctrl #(.TVEC_RESET(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .excep_valid(excep_valid), .excep_code(excep_code), .excep_pc(excep_pc),
    .ret_valid(ret_valid), .ret_from(ret_from),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .mode(mode), .busy(busy), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference privilege state, stored as the values a CSR read would return
  logic [1:0]  m_mode;
  logic        m_mie, m_mpie, m_sie, m_spie, m_spp;
  logic [1:0]  m_mpp;
  logic [31:0] m_medeleg, m_mtvec, m_mepc, m_mcause, m_stvec, m_sepc, m_scause;

  logic [11:0] csr_list [11] = '{12'h300, 12'h302, 12'h305, 12'h341, 12'h342,
                                 12'h100, 12'h105, 12'h141, 12'h142, 12'h343, 12'hF11};
  logic [3:0]  code_list [4] = '{4'd2, 4'd8, 4'd9, 4'd11};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 2'd3;
    m_mie = 0; m_mpie = 0; m_mpp = 0; m_sie = 0; m_spie = 0; m_spp = 0;
    m_medeleg = 0; m_mepc = 0; m_mcause = 0; m_sepc = 0; m_scause = 0;
    m_mtvec = 32'h100; m_stvec = 32'h100;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] v;
    v = 0;
    case (a)
      12'h300: begin v[3] = m_mie; v[7] = m_mpie; v[12:11] = m_mpp; end
      12'h305: v = m_mtvec;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h302: v = SMODE ? m_medeleg : 0;
      12'h100: if (SMODE) begin v[1] = m_sie; v[5] = m_spie; v[8] = m_spp; end
      12'h105: v = SMODE ? m_stvec : 0;
      12'h141: v = SMODE ? m_sepc : 0;
      12'h142: v = SMODE ? m_scause : 0;
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] w);
    case (a)
      12'h300: begin
        m_mie = w[3]; m_mpie = w[7];
        if (w[12:11] == 2'd3) m_mpp = 2'd3;
        else if (SMODE && w[12:11] == 2'd1) m_mpp = 2'd1;
        else m_mpp = 2'd0;
      end
      12'h305: m_mtvec = w & ~32'h3;
      12'h341: m_mepc = w & ~32'h3;
      12'h342: m_mcause = w;
      12'h302: if (SMODE) m_medeleg = w & 32'hFFFF;
      12'h100: if (SMODE) begin m_sie = w[1]; m_spie = w[5]; m_spp = w[8]; end
      12'h105: if (SMODE) m_stvec = w & ~32'h3;
      12'h141: if (SMODE) m_sepc = w & ~32'h3;
      12'h142: if (SMODE) m_scause = w;
      default: ;
    endcase
  endtask

  // Applies one accepted event to the model; returns the expected redirect target.
  task automatic model_event(input bit exc, input logic [3:0] code, input logic [31:0] pc,
                             input logic [1:0] rfrom, output logic [31:0] tgt);
    bit legal, to_s;
    if (!exc) begin
      // mret only from M; sret only from S or M and only with the supervisor set present
      legal = (rfrom == 2'd3 && m_mode == 2'd3) || (SMODE && rfrom == 2'd1 && m_mode != 2'd0);
      if (!legal) begin exc = 1; code = 4'd2; end
    end
    if (exc) begin
      to_s = SMODE && (m_mode != 2'd3) && m_medeleg[code];
      if (to_s) begin
        m_sepc = pc & ~32'h3; m_scause = {28'b0, code};
        m_spp = m_mode[0]; m_spie = m_sie; m_sie = 0;
        m_mode = 2'd1; tgt = m_stvec;
      end else begin
        m_mepc = pc & ~32'h3; m_mcause = {28'b0, code};
        m_mpp = (m_mode == 2'd3) ? 2'd3 : (SMODE ? m_mode : 2'd0);
        m_mpie = m_mie; m_mie = 0;
        m_mode = 2'd3; tgt = m_mtvec;
      end
    end else if (rfrom == 2'd3) begin
      m_mode = m_mpp; m_mie = m_mpie; m_mpie = 1; m_mpp = 2'd0; tgt = m_mepc;
    end else begin
      m_mode = {1'b0, m_spp}; m_sie = m_spie; m_spie = 1; m_spp = 0; tgt = m_sepc;
    end
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] w);
    @(negedge clk);
    csr_we = 1; csr_addr = a; csr_wdata = w;
    @(negedge clk);
    csr_we = 0;
    model_write(a, w);
  endtask

  task automatic read_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    @(negedge clk);
    csr_addr = a;
    #1 check(tag, csr_rdata, exp);
  endtask

  task automatic check_csrs();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      csr_addr = csr_list[i];
      #1 check($sformatf("csr_%h", csr_list[i]), csr_rdata, model_read(csr_list[i]));
    end
  endtask

  // Drives one request in cycle N and checks the N..N+3 timeline. With noise set, a CSR
  // write rides along in N and junk requests plus writes are held through the busy window.
  task automatic run_event(input bit exc, input logic [3:0] code, input logic [31:0] pc,
                           input bit ret, input logic [1:0] rfrom, input bit noise);
    logic [31:0] tgt;
    logic [1:0]  old_mode;
    old_mode = m_mode;
    @(negedge clk);
    excep_valid = exc; excep_code = code; excep_pc = pc; ret_valid = ret; ret_from = rfrom;
    if (noise) begin csr_we = 1; csr_addr = 12'h305; csr_wdata = $urandom; end
    #1;
    check("flush_n", 32'(flush), 32'd1);
    check("busy_n", 32'(busy), 32'd0);
    model_event(exc, code, pc, rfrom, tgt);
    @(negedge clk);
    if (noise) begin
      excep_valid = 1; ret_valid = 1; excep_code = 4'($urandom_range(0, 15));
      excep_pc = $urandom; csr_wdata = $urandom;
    end else begin
      excep_valid = 0; ret_valid = 0;
    end
    #1;
    check("busy_n1", 32'(busy), 32'd1);
    check("flush_n1", 32'(flush), 32'd1);
    check("rv_n1", 32'(redirect_valid), 32'd0);
    check("mode_n1", 32'(mode), 32'(old_mode));
    @(negedge clk);
    #1;
    check("rv_n2", 32'(redirect_valid), 32'd1);
    check("rpc_n2", redirect_pc, tgt);
    check("mode_n2", 32'(mode), 32'(m_mode));
    check("busy_n2", 32'(busy), 32'd1);
    check("flush_n2", 32'(flush), 32'd1);
    @(negedge clk);
    excep_valid = 0; ret_valid = 0; csr_we = 0;
    #1;
    check("busy_n3", 32'(busy), 32'd0);
    check("rv_n3", 32'(redirect_valid), 32'd0);
    check("flush_n3", 32'(flush), 32'd0);
  endtask

  bit          r_exc, r_ret;
  logic [3:0]  r_code;
  logic [1:0]  r_from;
  logic [11:0] r_addr;
  int unsigned r_kind;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1 check("rst_mode_low", 32'(mode), 32'd3);
    rst_n = 1;
    #1;
    check("rst_mode", 32'(mode), 32'd3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_rv", 32'(redirect_valid), 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    read_check("rst_mtvec", 12'h305, 32'h100);
    read_check("rst_mstatus", 12'h300, 32'h0);
    check_csrs();

    // drop to U via mret
    csr_write(12'h341, 32'h1000);
    csr_write(12'h300, 32'h0);
    run_event(0, 4'd0, 32'h0, 1, 2'd3, 0);
    check("to_user_mode", 32'(mode), 32'd0);

    // ecall from U, no delegation
    run_event(1, 4'd8, 32'h2000, 0, 2'd0, 0);
    check("ecall_rpc", redirect_pc, 32'h100);
    check("ecall_mode", 32'(mode), 32'd3);
    read_check("ecall_mepc", 12'h341, 32'h2000);
    read_check("ecall_mcause", 12'h342, 32'd8);
    read_check("ecall_mstatus", 12'h300, 32'h0);

    // mret with MPP=U, MPIE=1
    csr_write(12'h341, 32'h2004);
    csr_write(12'h300, 32'h80);
    run_event(0, 4'd0, 32'h0, 1, 2'd3, 0);
    check("mret_rpc", redirect_pc, 32'h2004);
    check("mret_mode", 32'(mode), 32'd0);
    read_check("mret_mstatus", 12'h300, 32'h88);

    if (SMODE) begin
      csr_write(12'h302, 32'h100);
      csr_write(12'h105, 32'h400);
      run_event(1, 4'd8, 32'h3000, 0, 2'd0, 0);
      check("deleg_mode", 32'(mode), 32'd1);
      check("deleg_rpc", redirect_pc, 32'h400);
      read_check("deleg_sepc", 12'h141, 32'h3000);
      read_check("deleg_scause", 12'h142, 32'd8);
      run_event(0, 4'd0, 32'h0, 1, 2'd1, 0);
      check("sret_mode", 32'(mode), 32'd0);
      check("sret_rpc", redirect_pc, 32'h3000);
      csr_write(12'h302, 32'h0);
    end

    // exception and return together, with writes offered while accepting/busy
    run_event(1, 4'd8, 32'h4000, 1, 2'd3, 1);
    check("both_mode", 32'(mode), 32'd3);
    check("both_rpc", redirect_pc, 32'h100);
    read_check("both_mcause", 12'h342, 32'd8);
    read_check("both_mtvec_kept", 12'h305, 32'h100);

    // back to U, then an illegal mret from U
    run_event(0, 4'd0, 32'h0, 1, 2'd3, 0);
    check("u_again", 32'(mode), 32'd0);
    run_event(0, 4'd0, 32'h5000, 1, 2'd3, 0);
    check("illegal_rpc", redirect_pc, 32'h100);
    check("illegal_mode", 32'(mode), 32'd3);
    read_check("illegal_mcause", 12'h342, 32'd2);
    read_check("illegal_mepc", 12'h341, 32'h5000);
    check_csrs();

    // reset while a trap from U sits in SAVE
    run_event(0, 4'd0, 32'h0, 1, 2'd3, 0);
    @(negedge clk);
    excep_valid = 1; excep_code = 4'd8; excep_pc = 32'h6000;
    @(negedge clk);
    excep_valid = 0;
    #1 check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 0;
    #1;
    check("midrst_mode", 32'(mode), 32'd3);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rv", 32'(redirect_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1 check("midrst_rv_hold", 32'(redirect_valid), 32'd0);
    end
    rst_n = 1;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      #1 check("midrst_rv_after", 32'(redirect_valid), 32'd0);
    end
    read_check("midrst_mepc", 12'h341, 32'h0);
    check("midrst_rpc", redirect_pc, 32'h0);
    check_csrs();

    for (int it = 0; it < 60; it++) begin
      r_kind = $urandom_range(0, 9);
      if (r_kind < 4) begin
        if ($urandom_range(0, 4) == 0) r_addr = 12'($urandom_range(0, 4095));
        else r_addr = csr_list[$urandom_range(0, 10)];
        csr_write(r_addr, $urandom);
      end else begin
        r_exc = (r_kind != 9) && ($urandom_range(0, 1) == 1);
        r_ret = !r_exc || ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) r_code = code_list[$urandom_range(0, 3)];
        else r_code = 4'($urandom_range(0, 15));
        r_from = 2'($urandom_range(0, 3));
        run_event(r_exc, r_code, $urandom, r_ret, r_from, $urandom_range(0, 1) == 1);
      end
      check("rand_mode", 32'(mode), 32'(m_mode));
      check_csrs();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
